// File: rtl/axis_frame_length_fifo_if.sv
// Bundle for axis_frame_length_fifo.
// Purpose: carries the tapped AXI-Stream monitor signals and the handshaked
// {length, status} record stream as one port.
//   mon_axis_*  : passive tap of the measured stream (tkeep/tvalid/tready/tlast/tuser)
//   m_len_*     : queued frame records (tdata = byte length, tuser = status)
// Modports:
//   slave  : the meter's view (samples the tap, drives the records)
//   master : the environment's view (drives the tap, consumes the records)
interface axis_frame_length_fifo_if #(
  parameter int KEEP_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
);
  logic [KEEP_WIDTH-1:0] mon_axis_tkeep;
  logic                  mon_axis_tvalid;
  logic                  mon_axis_tready;
  logic                  mon_axis_tlast;
  logic                  mon_axis_tuser;

  logic [LEN_WIDTH-1:0]  m_len_tdata;
  logic [3:0]            m_len_tuser;
  logic                  m_len_tvalid;
  logic                  m_len_tready;

  modport slave (
    input  mon_axis_tkeep, mon_axis_tvalid, mon_axis_tready, mon_axis_tlast, mon_axis_tuser,
    input  m_len_tready,
    output m_len_tdata, m_len_tuser, m_len_tvalid
  );

  modport master (
    output mon_axis_tkeep, mon_axis_tvalid, mon_axis_tready, mon_axis_tlast, mon_axis_tuser,
    output m_len_tready,
    input  m_len_tdata, m_len_tuser, m_len_tvalid
  );
endinterface

// File: rtl/axis_frame_length_fifo.sv
// axis_frame_length_fifo
// Purpose: measures each frame on a tapped AXI-Stream in bytes (tkeep popcount),
// classifies it (bad / runt / oversize / saturated) and queues a
// {length, status} record behind a registered output head.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   io (slave)        : mon_axis_* tap inputs, m_len_* record output handshake
//   fifo_count        : records held, 0..DEPTH (includes the output head)
//   drop_count        : saturating count of records lost to a full queue
//   status_overflow   : 1-cycle pulse when a record is lost
//   status_good_frame : 1-cycle pulse after a good frame's last beat
//   status_bad_frame  : 1-cycle pulse after a non-good frame's last beat
// m_len_tuser = {saturated, oversize, runt, bad}
module axis_frame_length_fifo #(
  parameter int   DATA_WIDTH           = 8,
  parameter int   KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int   KEEP_WIDTH           = (DATA_WIDTH / 8),
  parameter int   LEN_WIDTH            = 16,
  parameter int   MIN_LEN              = 64,
  parameter int   MAX_LEN              = 1522,
  parameter int   DEPTH                = 32,
  parameter int   FILTER_BAD           = 1,
  parameter logic USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic USER_BAD_FRAME_MASK  = 1'b1,
  parameter int   DROP_CNT_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axis_frame_length_fifo_if.slave     io,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count,
  output logic                        status_overflow,
  output logic                        status_good_frame,
  output logic                        status_bad_frame
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LEN_WIDTH:0] LEN_MAX = {1'b0, {LEN_WIDTH{1'b1}}};
  localparam logic [31:0] MIN_L   = 32'(MIN_LEN);
  localparam logic [31:0] MAX_L   = 32'(MAX_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
    logic [3:0]           user;
  } rec_t;

  // ---------------- measurement ----------------
  logic                 beat, last_beat;
  logic [LEN_WIDTH:0]   beat_bytes, sum;
  logic [LEN_WIDTH-1:0] len;
  logic [31:0]          len32;
  logic                 sat_now, saturated, bad, runt, oversize, good;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;

  always_comb begin
    beat_bytes = '0;
    if (KEEP_ENABLE != 0) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++)
        beat_bytes = beat_bytes + (LEN_WIDTH+1)'(io.mon_axis_tkeep[i]);
    end else begin
      beat_bytes = (LEN_WIDTH+1)'(KEEP_WIDTH);
    end
  end

  always_comb begin
    beat      = io.mon_axis_tvalid & io.mon_axis_tready;
    last_beat = beat & io.mon_axis_tlast;
    sum       = {1'b0, acc_q} + beat_bytes;
    sat_now   = (sum > LEN_MAX);
    len       = sat_now ? '1 : sum[LEN_WIDTH-1:0];
    len32     = 32'(len);
    saturated = sat_q | sat_now;
    bad       = ((io.mon_axis_tuser & USER_BAD_FRAME_MASK) ==
                 (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
    runt      = (len32 < MIN_L);
    oversize  = (len32 > MAX_L) | saturated;
    good      = ~bad & ~runt & ~oversize;

    acc_d = acc_q;
    sat_d = sat_q;
    if (beat) begin
      acc_d = io.mon_axis_tlast ? '0   : len;
      sat_d = io.mon_axis_tlast ? 1'b0 : saturated;
    end
  end

  // ---------------- record queue ----------------
  // count_q counts the head register plus the entries still in mem, so
  // mem never holds more than DEPTH-1 records.
  rec_t              mem [DEPTH];
  rec_t              head_q, head_d, push_rec;
  logic              head_vld_q, head_vld_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d, good_q, good_d, bad_q, bad_d;
  logic              pop, push_req, push_ok, mem_empty, mem_we;

  always_comb begin
    push_rec   = '{len: len, user: {saturated, oversize, runt, bad}};
    pop        = head_vld_q & io.m_len_tready;
    push_req   = last_beat & ((FILTER_BAD == 0) | good);
    push_ok    = push_req & ((count_q < DEPTH_C) | pop);
    mem_empty  = ((count_q - CW'(head_vld_q)) == '0);

    head_d     = head_q;
    head_vld_d = head_vld_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_we     = 1'b0;

    // Refill the head from mem first; a new record bypasses mem only when
    // nothing older is waiting, which keeps records in order.
    if (!head_vld_q || pop) begin
      if (!mem_empty) begin
        head_d     = mem[rd_ptr_q];
        head_vld_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(1);
        mem_we     = push_ok;
      end else if (push_ok) begin
        head_d     = push_rec;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else begin
      mem_we = push_ok;
    end
    if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d  = push_req & ~push_ok;
    drop_d = drop_q;
    if (ovf_d && (drop_q != '1)) drop_d = drop_q + DROP_CNT_WIDTH'(1);
    good_d = last_beat & good;
    bad_d  = last_beat & ~good;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      sat_q      <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign io.m_len_tdata   = head_q.len;
  assign io.m_len_tuser   = head_q.user;
  assign io.m_len_tvalid  = head_vld_q;
  assign fifo_count        = count_q;
  assign drop_count        = drop_q;
  assign status_overflow   = ovf_q;
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;

endmodule

// File: tb/tb_axis_frame_length_fifo.sv
// Bench for axis_frame_length_fifo: three instances share one tapped stream.
//   A: 64-bit, DEPTH=4,  FILTER_BAD=1, LEN_WIDTH=16 (consumer ready controlled)
//   B: 64-bit, DEPTH=32, FILTER_BAD=0, LEN_WIDTH=16 (random consumer ready)
//   C: 64-bit, DEPTH=8,  FILTER_BAD=0, LEN_WIDTH=8  (always ready)
module tb_axis_frame_length_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_keep;
  logic       s_valid, s_last, s_user, s_rdy;
  logic       rdy [3];
  bit         stall_en;

  int n_chk  = 0;
  int n_fail = 0;
  int ovf_seen = 0;

  axis_frame_length_fifo_if #(.KEEP_WIDTH(8), .LEN_WIDTH(16)) if_a ();
  axis_frame_length_fifo_if #(.KEEP_WIDTH(8), .LEN_WIDTH(16)) if_b ();
  axis_frame_length_fifo_if #(.KEEP_WIDTH(8), .LEN_WIDTH(8))  if_c ();

  assign if_a.mon_axis_tkeep = s_keep;  assign if_b.mon_axis_tkeep = s_keep;  assign if_c.mon_axis_tkeep = s_keep;
  assign if_a.mon_axis_tvalid = s_valid; assign if_b.mon_axis_tvalid = s_valid; assign if_c.mon_axis_tvalid = s_valid;
  assign if_a.mon_axis_tready = s_rdy;  assign if_b.mon_axis_tready = s_rdy;  assign if_c.mon_axis_tready = s_rdy;
  assign if_a.mon_axis_tlast = s_last;  assign if_b.mon_axis_tlast = s_last;  assign if_c.mon_axis_tlast = s_last;
  assign if_a.mon_axis_tuser = s_user;  assign if_b.mon_axis_tuser = s_user;  assign if_c.mon_axis_tuser = s_user;
  assign if_a.m_len_tready = rdy[0];    assign if_b.m_len_tready = rdy[1];    assign if_c.m_len_tready = rdy[2];

  logic [2:0]  cnt_a;
  logic [5:0]  cnt_b;
  logic [3:0]  cnt_c;
  logic [15:0] drp_a, drp_b, drp_c;
  logic        ovf_a, ovf_b, ovf_c, gd_a, gd_b, gd_c, bd_a, bd_b, bd_c;

  axis_frame_length_fifo #(.DATA_WIDTH(64), .DEPTH(4), .FILTER_BAD(1), .LEN_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .io(if_a.slave), .fifo_count(cnt_a), .drop_count(drp_a),
    .status_overflow(ovf_a), .status_good_frame(gd_a), .status_bad_frame(bd_a));
  axis_frame_length_fifo #(.DATA_WIDTH(64), .DEPTH(32), .FILTER_BAD(0), .LEN_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .io(if_b.slave), .fifo_count(cnt_b), .drop_count(drp_b),
    .status_overflow(ovf_b), .status_good_frame(gd_b), .status_bad_frame(bd_b));
  axis_frame_length_fifo #(.DATA_WIDTH(64), .DEPTH(8), .FILTER_BAD(0), .LEN_WIDTH(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .io(if_c.slave), .fifo_count(cnt_c), .drop_count(drp_c),
    .status_overflow(ovf_c), .status_good_frame(gd_c), .status_bad_frame(bd_c));

  logic [31:0] o_data [3], o_user [3], o_valid [3], o_cnt [3], o_drop [3], o_ovf [3], o_good [3], o_bad [3];
  assign o_data[0] = 32'(if_a.m_len_tdata);  assign o_data[1] = 32'(if_b.m_len_tdata);  assign o_data[2] = 32'(if_c.m_len_tdata);
  assign o_user[0] = 32'(if_a.m_len_tuser);  assign o_user[1] = 32'(if_b.m_len_tuser);  assign o_user[2] = 32'(if_c.m_len_tuser);
  assign o_valid[0] = 32'(if_a.m_len_tvalid); assign o_valid[1] = 32'(if_b.m_len_tvalid); assign o_valid[2] = 32'(if_c.m_len_tvalid);
  assign o_cnt[0] = 32'(cnt_a);  assign o_cnt[1] = 32'(cnt_b);  assign o_cnt[2] = 32'(cnt_c);
  assign o_drop[0] = 32'(drp_a); assign o_drop[1] = 32'(drp_b); assign o_drop[2] = 32'(drp_c);
  assign o_ovf[0] = 32'(ovf_a);  assign o_ovf[1] = 32'(ovf_b);  assign o_ovf[2] = 32'(ovf_c);
  assign o_good[0] = 32'(gd_a);  assign o_good[1] = 32'(gd_b);  assign o_good[2] = 32'(gd_c);
  assign o_bad[0] = 32'(bd_a);   assign o_bad[1] = 32'(bd_b);   assign o_bad[2] = 32'(bd_c);

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  int p_lenw [3] = '{16, 16, 8};
  int p_depth[3] = '{4, 32, 8};
  int p_filt [3] = '{1, 0, 0};
  int acc_m [3];
  bit sat_m [3];
  int drop_m[3];
  bit eg [3], eb [3], eo [3];
  logic [31:0] sb0[$], sb1[$], sb2[$];

  function automatic int sb_size(int i);
    case (i)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic void sb_push(int i, logic [31:0] v);
    case (i)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endfunction

  function automatic logic [31:0] sb_pop(int i);
    case (i)
      0: return sb0.pop_front();
      1: return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  function automatic void sb_clear(int i);
    case (i)
      0: sb0.delete();
      1: sb1.delete();
      default: sb2.delete();
    endcase
  endfunction

  task automatic monitor_one(int i);
    int sz, bytes, maxv, sum, len;
    bit pop, satnow, sf, bad, runt, over, good;
    logic [31:0] e;
    if (!rst_n) begin
      chk("rst_tvalid", o_valid[i], 0);
      chk("rst_tdata",  o_data[i], 0);
      chk("rst_tuser",  o_user[i], 0);
      chk("rst_count",  o_cnt[i], 0);
      chk("rst_drop",   o_drop[i], 0);
      chk("rst_pulses", o_ovf[i] | o_good[i] | o_bad[i], 0);
      sb_clear(i);
      acc_m[i] = 0; sat_m[i] = 0; drop_m[i] = 0;
      eg[i] = 0; eb[i] = 0; eo[i] = 0;
      return;
    end
    sz = sb_size(i);
    chk("fifo_count", o_cnt[i], sz);
    chk("tvalid", o_valid[i], 32'(sz != 0));
    chk("drop_count", o_drop[i], drop_m[i]);
    chk("good_pulse", o_good[i], 32'(eg[i]));
    chk("bad_pulse", o_bad[i], 32'(eb[i]));
    chk("overflow_pulse", o_ovf[i], 32'(eo[i]));
    eg[i] = 0; eb[i] = 0; eo[i] = 0;
    pop = o_valid[i][0] && rdy[i];
    if (pop && sz != 0) begin
      e = sb_pop(i);
      chk("tdata", o_data[i], 32'(e[15:0]));
      chk("tuser", o_user[i], 32'(e[19:16]));
    end
    if (s_valid && s_rdy) begin
      bytes  = $countones(s_keep);
      maxv   = (1 << p_lenw[i]) - 1;
      sum    = acc_m[i] + bytes;
      satnow = sum > maxv;
      len    = satnow ? maxv : sum;
      sf     = sat_m[i] | satnow;
      if (s_last) begin
        bad  = s_user;
        runt = len < 64;
        over = (len > 1522) || sf;
        good = !bad && !runt && !over;
        eg[i] = good;
        eb[i] = !good;
        if (p_filt[i] == 0 || good) begin
          if (sz < p_depth[i] || pop)
            sb_push(i, {12'd0, sf, over, runt, bad, len[15:0]});
          else begin
            eo[i] = 1;
            drop_m[i]++;
          end
        end
        acc_m[i] = 0; sat_m[i] = 0;
      end else begin
        acc_m[i] = len; sat_m[i] = sf;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) monitor_one(i);
    if (rst_n && ovf_a) ovf_seen++;
  end

  always @(posedge clk) begin
    #1;
    rdy[1] = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  task automatic idle(int n);
    s_valid = 0;
    s_last  = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(logic [7:0] k, logic l, logic u);
    if (stall_en && $urandom_range(0, 3) == 0) begin
      s_valid = 1; s_rdy = 0; s_keep = 8'hA5; s_last = 1'($urandom_range(0, 1)); s_user = 1;
      @(posedge clk); #1;
    end
    s_valid = 1; s_rdy = 1; s_keep = k; s_last = l; s_user = u;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(int n, logic u, bit pop_on_last);
    int rem;
    logic [7:0] k;
    rem = n;
    while (rem > 8) begin
      beat(8'hFF, 0, 0);
      rem -= 8;
    end
    k = (rem == 8) ? 8'hFF : 8'((1 << rem) - 1);
    if (pop_on_last) rdy[0] = 1;
    beat(k, 1, u);
    if (pop_on_last) rdy[0] = 0;
    s_valid = 0;
    s_last  = 0;
  endtask

  task automatic wait_empty(int i);
    for (int c = 0; c < 2000 && o_cnt[i] != 0; c++) begin @(posedge clk); #1; end
    chk("drain_count", o_cnt[i], 0);
  endtask

  initial begin
    s_valid = 0; s_rdy = 1; s_keep = '0; s_last = 0; s_user = 0;
    rdy[0] = 1; rdy[1] = 1; rdy[2] = 1;
    stall_en = 0;
    rst_n = 0;
    idle(3);
    rst_n = 1;
    idle(2);

    // 9 beats: 8 x FF then 0F -> 68 bytes, record visible one cycle after tlast
    send_frame(68, 0, 0);
    chk("t1_tvalid", o_valid[0], 1);
    chk("t1_tdata", o_data[0], 68);
    chk("t1_tuser", o_user[0], 0);
    chk("t1_good_pulse", o_good[0], 1);
    idle(3);

    // back-to-back 64 / 60 / 1600(bad)
    send_frame(64, 0, 0);
    send_frame(60, 0, 0);
    send_frame(1600, 1, 0);
    idle(4);

    // zero-keep beat inside a 64-byte frame
    beat(8'hFF, 0, 0); beat(8'hFF, 0, 0); beat(8'h00, 0, 0); beat(8'hFF, 0, 0);
    beat(8'hFF, 0, 0); beat(8'hFF, 0, 0); beat(8'hFF, 0, 0); beat(8'hFF, 0, 0);
    beat(8'hFF, 1, 0);
    idle(3);

    // 300 bytes saturates the 8-bit instance
    send_frame(300, 0, 0);
    chk("sat_tdata_c", o_data[2], 255);
    chk("sat_tuser_c", o_user[2], 4'b1100);
    idle(3);

    stall_en = 1;
    for (int f = 0; f < 8; f++) send_frame($urandom_range(1, 200), 1'($urandom_range(0, 1)), 0);
    stall_en = 0;
    idle(5);

    // fill A (DEPTH=4) with six good frames while stalled
    wait_empty(0);
    rdy[0] = 0;
    ovf_seen = 0;
    repeat (6) send_frame(64, 0, 0);
    idle(3);
    chk("fill_count", o_cnt[0], 4);
    chk("fill_drop", o_drop[0], 2);
    chk("fill_ovf_pulses", ovf_seen, 2);

    // full queue, last beat coincides with a pop -> accepted
    send_frame(64, 0, 1);
    idle(2);
    chk("coinc_count", o_cnt[0], 4);
    chk("coinc_drop", o_drop[0], 2);
    chk("coinc_ovf_pulses", ovf_seen, 2);
    rdy[0] = 1;
    wait_empty(0);

    // reset mid-frame, then one clean 64-byte frame
    beat(8'hFF, 0, 0); beat(8'hFF, 0, 0); beat(8'hFF, 0, 0);
    s_valid = 0;
    rst_n = 0;
    idle(3);
    rst_n = 1;
    idle(1);
    send_frame(64, 0, 0);
    chk("post_rst_tdata", o_data[0], 64);
    chk("post_rst_tvalid", o_valid[0], 1);
    idle(3);

    for (int i = 0; i < 3; i++) rdy[i] = 1;
    wait_empty(0);
    wait_empty(1);
    wait_empty(2);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
